tick_counter: RTL and testbench

Parametrised successor to the board's first LED counter: a modulo-N up/down counter advanced by an internal prescaler tick in the single `clk` domain, with synchronous load and clear. It drives board LEDs from PMOD inputs and replaces the divided-clock scheme with a clock-enable tick, so all state stays on `clk`. It also exports `tick` and `wrap` strobes so later blocks can cascade counters.

---
 rtl/tick_counter.sv | 102 ++++++++++
 tb/tb_tick_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tick_counter.sv
// Modulo-N up/down counter advanced by an internal prescaler tick, all on clk.
// Define TICK_COUNTER_SYNC_EN to put 2-flop synchronizers on en, dir and clr.
module tick_counter #(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4,
  parameter int MODULO  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  P_LAST  = PW'(DIV - 1);
  // One bit wider so MODULO = 2^WIDTH fits without an overflow case.
  localparam logic [WIDTH:0] MOD_MAX = (WIDTH + 1)'(MODULO - 1);

  logic          en_s;
  logic          dir_s;
  logic          clr_s;
  logic [PW-1:0] p;

`ifdef TICK_COUNTER_SYNC_EN
  logic [1:0] en_sync;
  logic [1:0] dir_sync;
  logic [1:0] clr_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_sync  <= 2'b00;
      dir_sync <= 2'b00;
      clr_sync <= 2'b00;
    end else begin
      en_sync  <= {en_sync[0], en};
      dir_sync <= {dir_sync[0], dir};
      clr_sync <= {clr_sync[0], clr};
    end
  end

  assign en_s  = en_sync[1];
  assign dir_s = dir_sync[1];
  assign clr_s = clr_sync[1];
`else
  assign en_s  = en;
  assign dir_s = dir;
  assign clr_s = clr;
`endif

  assign tick = (p == P_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (clr_s || tick) begin
      p <= '0;
    end else begin
      p <= p + PW'(1);
    end
  end

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  assign at_max       = ({1'b0, count} == MOD_MAX);
  assign at_zero      = (count == '0);
  assign load_clamped = ({1'b0, load_value} > MOD_MAX) ? MOD_MAX[WIDTH-1:0] : load_value;

  // A load on a tick edge discards that tick's step entirely, including wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr_s) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (tick && en_s) begin
      if (dir_s) begin
        count <= at_max ? '0 : count + WIDTH'(1);
        wrap  <= at_max;
      end else begin
        count <= at_zero ? MOD_MAX[WIDTH-1:0] : count - WIDTH'(1);
        wrap  <= at_zero;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// Randomized bench for tick_counter: two instances (MODULO 16 and 10, DIV 4)
// share stimulus and are compared every cycle against an arithmetic model.
module tb_tick_counter;

  localparam int DIV   = 4;
  localparam int MOD_A = 16;
  localparam int MOD_B = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] count_a, count_b;
  logic       tick_a, tick_b, wrap_a, wrap_b;

  int n_vec = 0;
  int n_err = 0;

  tick_counter #(.CLK_HZ(4), .TICK_HZ(1), .WIDTH(4), .MODULO(MOD_A)) dut_a (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_value(load_value), .count(count_a), .tick(tick_a), .wrap(wrap_a));

  tick_counter #(.CLK_HZ(4), .TICK_HZ(1), .WIDTH(4), .MODULO(MOD_B)) dut_b (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_value(load_value), .count(count_b), .tick(tick_b), .wrap(wrap_b));

  always #5 clk = ~clk;

  // Reference model: prescaler phase, counts and wrap flags as plain integers.
  int mp, mc_a, mc_b;
  bit mw_a, mw_b;
  bit en_d1, en_d2, dir_d1, dir_d2, clr_d1, clr_d2;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mp = 0; mc_a = 0; mc_b = 0; mw_a = 0; mw_b = 0;
    en_d1 = 0; en_d2 = 0; dir_d1 = 0; dir_d2 = 0; clr_d1 = 0; clr_d2 = 0;
  endtask

  task automatic model_count(input int m, input bit ld, input int lv, input bit stp,
                             input bit up, inout int c, inout bit w);
    w = 0;
    if (ld) c = (lv > m - 1) ? m - 1 : lv;
    else if (stp && up) begin
      w = (c == m - 1);
      c = (c + 1) % m;
    end else if (stp) begin
      w = (c == 0);
      c = (c + m - 1) % m;
    end
  endtask

  task automatic model_edge(input bit e, input bit d, input bit c, input bit l, input int lv);
    bit e_eff, d_eff, c_eff, tk;
`ifdef TICK_COUNTER_SYNC_EN
    e_eff = en_d2; d_eff = dir_d2; c_eff = clr_d2;
    en_d2 = en_d1; dir_d2 = dir_d1; clr_d2 = clr_d1;
    en_d1 = e; dir_d1 = d; clr_d1 = c;
`else
    e_eff = e; d_eff = d; c_eff = c;
`endif
    tk = (mp == DIV - 1);
    if (c_eff) begin
      mp = 0; mc_a = 0; mc_b = 0; mw_a = 0; mw_b = 0;
    end else begin
      mp = (mp + 1) % DIV;
      model_count(MOD_A, l, lv, tk && e_eff, d_eff, mc_a, mw_a);
      model_count(MOD_B, l, lv, tk && e_eff, d_eff, mc_b, mw_b);
    end
  endtask

  task automatic compare_all();
    check_val("count_a", int'(count_a), mc_a);
    check_val("count_b", int'(count_b), mc_b);
    check_val("tick_a", int'(tick_a), int'(mp == DIV - 1));
    check_val("tick_b", int'(tick_b), int'(mp == DIV - 1));
    check_val("wrap_a", int'(wrap_a), int'(mw_a));
    check_val("wrap_b", int'(wrap_b), int'(mw_b));
  endtask

  // Called at a negedge: drive inputs for the next edge, advance, compare.
  task automatic step(input bit e, input bit d, input bit c, input bit l, input int lv);
    en = e; dir = d; clr = c; load = l; load_value = 4'(lv);
    model_edge(e, d, c, l, lv);
    @(negedge clk);
    compare_all();
  endtask

  int wraps_a, ticks_seen;
  bit cur_en, cur_dir;

  initial begin
    model_reset();
    #1;
    check_val("reset_count_a", int'(count_a), 0);
    check_val("reset_tick_a", int'(tick_a), 0);
    check_val("reset_wrap_a", int'(wrap_a), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Up count: 20 ticks from reset, single wrap on the MODULO-16 instance.
    wraps_a = 0;
    for (int i = 0; i < 80; i++) begin
      step(1, 1, 0, 0, 0);
      if (wrap_a) wraps_a++;
    end
    check_val("up20_count_a", int'(count_a), 4);
    check_val("up20_wraps_a", wraps_a, 1);
    check_val("up20_count_b", int'(count_b), 0);

    // Down from 0 on MODULO 10: next tick is edge 84.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    check_val("down_count_b", int'(count_b), 9);
    check_val("down_wrap_b", int'(wrap_b), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    check_val("down2_count_b", int'(count_b), 8);

    // Load on a tick edge (edge 92) wins over the step.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    check_val("pre_load_tick", int'(tick_a), 1);
    step(1, 1, 0, 1, 7);
    check_val("load_beats_count", int'(count_a), 7);
    check_val("load_beats_wrap", int'(wrap_a), 0);
    step(1, 1, 0, 1, 12);
    check_val("clamp_count_b", int'(count_b), 9);
    check_val("clamp_count_a", int'(count_a), 12);

    // Enable low: ticks keep coming, count holds.
    ticks_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 0, 0);
      if (tick_a) ticks_seen++;
    end
    check_val("en_low_ticks", ticks_seen, 10);
    step(0, 1, 1, 0, 0);
`ifdef TICK_COUNTER_SYNC_EN
    step(0, 1, 0, 0, 0);
`endif
    step(0, 1, 0, 0, 0);
    check_val("clr_count_a", int'(count_a), 0);

    // Randomized phase with occasional async reset between edges.
    cur_en = 1; cur_dir = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) cur_dir = ~cur_dir;
      if ($urandom_range(0, 39) == 0) cur_en = ~cur_en;
      step(cur_en, cur_dir, $urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
           int'($urandom_range(0, 15)));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_count_a", int'(count_a), 0);
        check_val("async_rst_tick_a", int'(tick_a), 0);
        check_val("async_rst_wrap_a", int'(wrap_a), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
